// File: rtl/corelet_pkg.sv
// rtl/corelet_pkg.sv - shared types, sizes and lane helper for the psum accumulator
package corelet_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int NUM_KIJ = 9;
  localparam int NUM_OUT = 16;
  localparam int ADDR_W  = 9;
  localparam int ROW_W   = COL * PSUM_BW;
  localparam int CNT_W   = $clog2(NUM_OUT);

  localparam logic [ADDR_W-1:0] PMEM_BASE = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RD,
    ACC,
    WR,
    FIN
  } psum_acc_ctrl_state_t;

  // Extract lane `lane` of a packed row.
  function automatic logic [PSUM_BW-1:0] lane_slice(input logic [ROW_W-1:0] row, input int lane);
    return row[lane*PSUM_BW +: PSUM_BW];
  endfunction

endpackage

// File: rtl/psum_acc_ctrl_if.sv
// rtl/psum_acc_ctrl_if.sv - ofifo pop port and PMEM (OP) SRAM port bundle
interface psum_acc_ctrl_if;
  import corelet_pkg::*;

  logic             ofifo_valid;
  logic             ofifo_rd;
  logic [ROW_W-1:0] ofifo_out;
  logic [ROW_W-1:0] OP_q;
  logic [ROW_W-1:0] OP_d;
  logic [ADDR_W-1:0] OP_addr;
  logic             OP_cen;
  logic             OP_wen;

  // master: the accumulator controller
  modport master (
    input  ofifo_valid, ofifo_out, OP_q,
    output ofifo_rd, OP_d, OP_addr, OP_cen, OP_wen
  );

  // slave: the ofifo and PMEM side
  modport slave (
    output ofifo_valid, ofifo_out, OP_q,
    input  ofifo_rd, OP_d, OP_addr, OP_cen, OP_wen
  );

endinterface

// File: rtl/psum_lane_add.sv
// rtl/psum_lane_add.sv - one psum lane adder with optional ReLU; PSUM_SAT_EN selects saturating add
module psum_lane_add
  import corelet_pkg::*;
(
  input  logic [PSUM_BW-1:0] a,
  input  logic [PSUM_BW-1:0] b,
  input  logic               relu_en,
  output logic [PSUM_BW-1:0] y
);

  logic [PSUM_BW-1:0] sum;

`ifdef PSUM_SAT_EN
  logic [PSUM_BW:0] wide;

  // Sign-extended add; clamp when the two top bits disagree (overflow)
  always_comb begin
    wide = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
    if (wide[PSUM_BW] != wide[PSUM_BW-1]) begin
      sum = wide[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
    end else begin
      sum = wide[PSUM_BW-1:0];
    end
  end
`else
  assign sum = a + b;
`endif

  // ReLU after the add (and after any clamp)
  assign y = (relu_en && sum[PSUM_BW-1]) ? '0 : sum;

endmodule

// File: rtl/psum_acc_ctrl.sv
// rtl/psum_acc_ctrl.sv - per-kij-pass PMEM write / read-modify-write sequencer
module psum_acc_ctrl
  import corelet_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      kij_idx,
  output logic            busy,
  output logic            done,
  psum_acc_ctrl_if.master bus
);

  psum_acc_ctrl_state_t state, state_nxt;
  logic [CNT_W-1:0] row_cnt, row_cnt_nxt;
  logic [ROW_W-1:0] row_reg, row_reg_nxt;
  logic [3:0]       kij_reg, kij_nxt;
  logic [ROW_W-1:0] add_a, add_b, add_y;
  logic             relu_en;
  logic             ofifo_rd;
  logic             op_cen;
  logic             op_wen;

  // Adder operands: accumulate PMEM data in ACC, otherwise pass the ofifo row
  // through with b=0 so ReLU-at-load reuses the same lanes.
  always_comb begin
    if (state == ACC) begin
      add_a   = row_reg;
      add_b   = bus.OP_q;
      relu_en = (kij_reg == 4'(NUM_KIJ - 1));
    end else begin
      add_a   = bus.ofifo_out;
      add_b   = '0;
      relu_en = (kij_reg == 4'd0) && (NUM_KIJ == 1);
    end
  end

  for (genvar i = 0; i < COL; i++) begin : g_lane
    psum_lane_add u_lane (
      .a       (lane_slice(add_a, i)),
      .b       (lane_slice(add_b, i)),
      .relu_en (relu_en),
      .y       (add_y[i*PSUM_BW +: PSUM_BW])
    );
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      row_cnt <= '0;
      row_reg <= '0;
      kij_reg <= '0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
      row_reg <= row_reg_nxt;
      kij_reg <= kij_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    row_reg_nxt = row_reg;
    kij_nxt     = kij_reg;
    busy        = (state != IDLE);
    done        = 1'b0;
    ofifo_rd    = 1'b0;
    op_cen      = 1'b1;
    op_wen      = 1'b1;
    case (state)
      IDLE: begin
        if (start && (kij_idx < 4'(NUM_KIJ))) begin
          kij_nxt     = kij_idx;
          row_cnt_nxt = '0;
          state_nxt   = FETCH;
        end
      end
      FETCH: begin
        if (bus.ofifo_valid) begin
          ofifo_rd    = 1'b1;
          row_reg_nxt = add_y;
          state_nxt   = (kij_reg == 4'd0) ? WR : RD;
        end
      end
      RD: begin
        op_cen    = 1'b0;
        state_nxt = ACC;
      end
      ACC: begin
        row_reg_nxt = add_y;
        state_nxt   = WR;
      end
      WR: begin
        op_cen = 1'b0;
        op_wen = 1'b0;
        if (row_cnt == CNT_W'(NUM_OUT - 1)) begin
          state_nxt = FIN;
        end else begin
          row_cnt_nxt = row_cnt + 1'b1;
          state_nxt   = FETCH;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ofifo_rd = ofifo_rd;
  assign bus.OP_cen   = op_cen;
  assign bus.OP_wen   = op_wen;
  assign bus.OP_addr  = PMEM_BASE + ADDR_W'(row_cnt);
  assign bus.OP_d     = row_reg;

endmodule
